// File: rtl/fft_pingpong_ram.sv
// Ping-pong sample banks for the FFT engine: store, butterfly read/write-back
// and output accesses, plus the one-cycle end handshakes back to the control unit.
module fft_pingpong_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13,
  parameter int BF_LAT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [4:0]        i_n_cfg,
  input  logic [1:0]        i_ram1_ctrl,
  input  logic [1:0]        i_ram2_ctrl,
  input  logic              i_store_valid,
  input  logic [15:0]       i_store_addr,
  input  logic [DATA_W-1:0] i_store_data,
  input  logic              i_di_valid,
  input  logic [15:0]       i_di_1_addr,
  input  logic [15:0]       i_di_2_addr,
  output logic [DATA_W-1:0] o_x1,
  output logic [DATA_W-1:0] o_x2,
  output logic              o_x_valid,
  input  logic              i_y_valid,
  input  logic [DATA_W-1:0] i_y1,
  input  logic [DATA_W-1:0] i_y2,
  input  logic              i_d_out_valid,
  input  logic [15:0]       i_d_out_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_valid,
  output logic              o_store_end,
  output logic              o_cal_end,
  output logic              o_output_end,
  output logic              o_err
);

  localparam int         DEPTH = 1 << ADDR_W;
  localparam int         CAL_W = ADDR_W + $clog2(ADDR_W);
  localparam logic [4:0] N_MAX = 5'(ADDR_W);

  localparam logic [1:0] CTRL_IDLE = 2'b00;
  localparam logic [1:0] CTRL_RD   = 2'b01;
  localparam logic [1:0] CTRL_WR   = 2'b10;

  typedef struct packed {
    logic              valid;
    logic              bank;
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
  } wb_entry_t;

  logic [DATA_W-1:0] mem [2][DEPTH];

  logic [4:0]        n_q, n_d, n_clamp, n_eff, shamt;
  logic [ADDR_W-1:0] store_cnt_q, store_cnt_d, out_cnt_q, out_cnt_d, last_idx;
  logic [CAL_W-1:0]  cal_cnt_q, cal_cnt_d, cal_last;
  logic              store_end_q, store_end_d, cal_end_q, cal_end_d;
  logic [DATA_W-1:0] x1_q, x1_d, x2_q, x2_d, data_q, data_d;
  logic              x_valid_q, x_valid_d, data_valid_q, data_valid_d;
  logic              err_q, err_d;
  wb_entry_t         dl_q [BF_LAT+1];
  wb_entry_t         dl_d [BF_LAT+1];
  wb_entry_t         tail;

  logic              idle, rd_bank, rd_ok, wr_bank, wr_ok, both_wr, any_strobe;
  logic              wb_conflict, wb_en;
  logic              we_a [2];
  logic              we_b [2];
  logic [ADDR_W-1:0] wa_a [2];
  logic [ADDR_W-1:0] wa_b [2];
  logic [DATA_W-1:0] wd_a [2];
  logic [DATA_W-1:0] wd_b [2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_store_addr[15:ADDR_W], i_di_1_addr[15:ADDR_W],
                              i_di_2_addr[15:ADDR_W], i_d_out_addr[15:ADDR_W]};

  assign tail = dl_q[BF_LAT];

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    n_clamp = i_n_cfg;
    if (i_n_cfg == 5'd0)  n_clamp = 5'd1;
    if (i_n_cfg > N_MAX)  n_clamp = N_MAX;

    // Frame length only follows the control unit between frames.
    idle     = (store_cnt_q == '0) && (cal_cnt_q == '0) && (out_cnt_q == '0);
    n_eff    = idle ? n_clamp : n_q;
    n_d      = n_eff;
    shamt    = N_MAX - n_eff;
    last_idx = {ADDR_W{1'b1}} >> shamt;
    cal_last = (CAL_W'(n_eff) << (n_eff - 5'd1)) - CAL_W'(1);

    rd_ok      = (i_ram1_ctrl == CTRL_RD) || (i_ram2_ctrl == CTRL_RD);
    rd_bank    = (i_ram1_ctrl == CTRL_RD) ? 1'b0 : 1'b1;
    wr_ok      = (i_ram1_ctrl == CTRL_WR) || (i_ram2_ctrl == CTRL_WR);
    wr_bank    = (i_ram1_ctrl == CTRL_WR) ? 1'b0 : 1'b1;
    both_wr    = (i_ram1_ctrl == CTRL_WR) && (i_ram2_ctrl == CTRL_WR);
    any_strobe = i_store_valid | i_di_valid | i_y_valid | i_d_out_valid;

    // Stores always target RAM1, so a write-back to RAM1 in the same cycle loses.
    wb_conflict = i_store_valid && i_y_valid && (tail.bank == 1'b0);
    wb_en       = i_y_valid && !wb_conflict;
  end

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      we_a[b] = 1'b0;
      we_b[b] = 1'b0;
      wa_a[b] = '0;
      wa_b[b] = '0;
      wd_a[b] = '0;
      wd_b[b] = '0;
    end
    if (i_store_valid) begin
      we_a[0] = 1'b1;
      wa_a[0] = i_store_addr[ADDR_W-1:0];
      wd_a[0] = i_store_data;
    end
    if (wb_en) begin
      we_a[tail.bank] = 1'b1;
      wa_a[tail.bank] = tail.a1;
      wd_a[tail.bank] = i_y1;
      we_b[tail.bank] = 1'b1;
      wa_b[tail.bank] = tail.a2;
      wd_b[tail.bank] = i_y2;
    end
  end

  // NOTE: the sample banks have no reset; they are plain RAM and every frame rewrites them.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 2; b++) begin
      if (we_a[b]) mem[b][wa_a[b]] <= wd_a[b];
      if (we_b[b]) mem[b][wa_b[b]] <= wd_b[b];
    end
  end

  always_comb begin
    x_valid_d    = i_di_valid;
    x1_d         = x1_q;
    x2_d         = x2_q;
    data_valid_d = i_d_out_valid;
    data_d       = data_q;
    if (i_di_valid) begin
      x1_d = mem[rd_bank][i_di_1_addr[ADDR_W-1:0]];
      x2_d = mem[rd_bank][i_di_2_addr[ADDR_W-1:0]];
    end
    if (i_d_out_valid) data_d = mem[rd_bank][i_d_out_addr[ADDR_W-1:0]];

    dl_d[0] = '{valid: i_di_valid, bank: wr_bank,
                a1: i_di_1_addr[ADDR_W-1:0], a2: i_di_2_addr[ADDR_W-1:0]};
    for (int k = 1; k <= BF_LAT; k++) dl_d[k] = dl_q[k-1];
  end

  always_comb begin
    store_cnt_d = store_cnt_q;
    store_end_d = 1'b0;
    if (i_store_valid) begin
      if (store_cnt_q == last_idx) begin
        store_cnt_d = '0;
        store_end_d = 1'b1;
      end else begin
        store_cnt_d = store_cnt_q + ADDR_W'(1);
      end
    end

    cal_cnt_d = cal_cnt_q;
    cal_end_d = 1'b0;
    if (i_y_valid) begin
      if (cal_cnt_q == cal_last) begin
        cal_cnt_d = '0;
        cal_end_d = 1'b1;
      end else begin
        cal_cnt_d = cal_cnt_q + CAL_W'(1);
      end
    end

    out_cnt_d = out_cnt_q;
    if (data_valid_q) out_cnt_d = (out_cnt_q == last_idx) ? '0 : out_cnt_q + ADDR_W'(1);

    err_d = err_q
          | (i_y_valid != tail.valid)
          | (both_wr && any_strobe)
          | (i_store_valid && (i_ram1_ctrl == CTRL_IDLE))
          | (i_di_valid && !(rd_ok && wr_ok))
          | (i_d_out_valid && !rd_ok)
          | wb_conflict;
  end

  // NOTE: state updates use <= so every flop samples the values from before the edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      n_q          <= 5'd1;
      store_cnt_q  <= '0;
      cal_cnt_q    <= '0;
      out_cnt_q    <= '0;
      store_end_q  <= 1'b0;
      cal_end_q    <= 1'b0;
      x1_q         <= '0;
      x2_q         <= '0;
      x_valid_q    <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      err_q        <= 1'b0;
      for (int k = 0; k <= BF_LAT; k++) dl_q[k] <= '0;
    end else begin
      n_q          <= n_d;
      store_cnt_q  <= store_cnt_d;
      cal_cnt_q    <= cal_cnt_d;
      out_cnt_q    <= out_cnt_d;
      store_end_q  <= store_end_d;
      cal_end_q    <= cal_end_d;
      x1_q         <= x1_d;
      x2_q         <= x2_d;
      x_valid_q    <= x_valid_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      err_q        <= err_d;
      for (int k = 0; k <= BF_LAT; k++) dl_q[k] <= dl_d[k];
    end
  end

  assign o_x1         = x1_q;
  assign o_x2         = x2_q;
  assign o_x_valid    = x_valid_q;
  assign o_data       = data_q;
  assign o_data_valid = data_valid_q;
  assign o_store_end  = store_end_q;
  assign o_cal_end    = cal_end_q;
  assign o_output_end = data_valid_q && (out_cnt_q == last_idx);
  assign o_err        = err_q;

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Directed bench for fft_pingpong_ram: n=3 store/compute/output frame,
// protocol error, mid-compute reset and the n=13 store wrap.
module tb_fft_pingpong_ram;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 13;
  localparam int BF_LAT = 4;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic [4:0]        i_n_cfg;
  logic [1:0]        i_ram1_ctrl, i_ram2_ctrl;
  logic              i_store_valid;
  logic [15:0]       i_store_addr;
  logic [DATA_W-1:0] i_store_data;
  logic              i_di_valid;
  logic [15:0]       i_di_1_addr, i_di_2_addr;
  logic [DATA_W-1:0] o_x1, o_x2;
  logic              o_x_valid;
  logic              i_y_valid;
  logic [DATA_W-1:0] i_y1, i_y2;
  logic              i_d_out_valid;
  logic [15:0]       i_d_out_addr;
  logic [DATA_W-1:0] o_data;
  logic              o_data_valid, o_store_end, o_cal_end, o_output_end, o_err;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  fft_pingpong_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BF_LAT(BF_LAT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_n_cfg(i_n_cfg),
    .i_ram1_ctrl(i_ram1_ctrl), .i_ram2_ctrl(i_ram2_ctrl),
    .i_store_valid(i_store_valid), .i_store_addr(i_store_addr), .i_store_data(i_store_data),
    .i_di_valid(i_di_valid), .i_di_1_addr(i_di_1_addr), .i_di_2_addr(i_di_2_addr),
    .o_x1(o_x1), .o_x2(o_x2), .o_x_valid(o_x_valid),
    .i_y_valid(i_y_valid), .i_y1(i_y1), .i_y2(i_y2),
    .i_d_out_valid(i_d_out_valid), .i_d_out_addr(i_d_out_addr),
    .o_data(o_data), .o_data_valid(o_data_valid),
    .o_store_end(o_store_end), .o_cal_end(o_cal_end), .o_output_end(o_output_end),
    .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Issue one operand read and return y = x + 1 after 'lat' extra cycles.
  task automatic butterfly(input logic [1:0] c1, input logic [1:0] c2, input int a1, input int a2,
                           input int lat, output logic [31:0] x1, output logic [31:0] x2,
                           output logic xv, output logic xv_next, output logic ce);
    i_ram1_ctrl = c1;
    i_ram2_ctrl = c2;
    i_di_valid  = 1'b1;
    i_di_1_addr = 16'(a1);
    i_di_2_addr = 16'(a2);
    step();
    i_di_valid = 1'b0;
    xv = o_x_valid;
    x1 = o_x1;
    x2 = o_x2;
    xv_next = 1'b0;
    for (int i = 0; i < lat; i++) begin
      step();
      if (i == 0) xv_next = o_x_valid;
    end
    i_y_valid = 1'b1;
    i_y1 = x1 + 32'd1;
    i_y2 = x2 + 32'd1;
    step();
    i_y_valid = 1'b0;
    ce = o_cal_end;
  endtask

  task automatic test_reset();
    chk_cnt++; if ({o_store_end, o_cal_end, o_output_end, o_err} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {o_store_end, o_cal_end, o_output_end, o_err}); else pass_cnt++;
    chk_cnt++; if ({o_x_valid, o_data_valid} !== 2'b0) $display("FAIL reset_valids: got %b want 00", {o_x_valid, o_data_valid}); else pass_cnt++;
    chk_cnt++; if ({o_x1, o_x2, o_data} !== 96'b0) $display("FAIL reset_data: got %h %h %h want 0", o_x1, o_x2, o_data); else pass_cnt++;
  endtask

  task automatic test_store();
    int br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int early = 0;
    logic last;
    i_n_cfg = 5'd3;
    i_ram1_ctrl = 2'b10;
    i_ram2_ctrl = 2'b00;
    for (int k = 0; k < 8; k++) begin
      i_store_valid = 1'b1;
      i_store_addr  = 16'(br[k]);
      i_store_data  = 32'(k);
      step();
      if (k < 7 && o_store_end) early++;
    end
    last = o_store_end;
    i_store_valid = 1'b0;
    chk_cnt++; if (early !== 0) $display("FAIL store_end_early: got %0d pulses want 0", early); else pass_cnt++;
    chk_cnt++; if (last !== 1'b1) $display("FAIL store_end_last: got %b want 1", last); else pass_cnt++;
    step();
    chk_cnt++; if (o_store_end !== 1'b0) $display("FAIL store_end_width: got %b want 0", o_store_end); else pass_cnt++;
  endtask

  task automatic test_stage0();
    int p1 [4] = '{0, 2, 4, 6};
    int e1 [4] = '{0, 2, 1, 3};
    int e2 [4] = '{4, 6, 5, 7};
    logic [31:0] x1, x2;
    logic xv, xvn, ce;
    for (int i = 0; i < 4; i++) begin
      butterfly(2'b01, 2'b10, p1[i], p1[i] + 1, BF_LAT, x1, x2, xv, xvn, ce);
      chk_cnt++; if (xv !== 1'b1 || xvn !== 1'b0) $display("FAIL s0_x_valid[%0d]: got %b%b want 10", i, xv, xvn); else pass_cnt++;
      chk_cnt++; if (x1 !== 32'(e1[i]) || x2 !== 32'(e2[i])) $display("FAIL s0_x[%0d]: got %0d,%0d want %0d,%0d", i, x1, x2, e1[i], e2[i]); else pass_cnt++;
      chk_cnt++; if (o_x1 !== 32'(e1[i])) $display("FAIL s0_x_hold[%0d]: got %0d want %0d", i, o_x1, e1[i]); else pass_cnt++;
    end
    chk_cnt++; if (ce !== 1'b0) $display("FAIL s0_cal_end: got %b want 0", ce); else pass_cnt++;
    chk_cnt++; if (o_err !== 1'b0) $display("FAIL s0_err: got %b want 0", o_err); else pass_cnt++;
  endtask

  task automatic test_compute();
    int a1 [8] = '{0, 1, 4, 5, 0, 1, 2, 3};
    int a2 [8] = '{2, 3, 6, 7, 4, 5, 6, 7};
    int e1 [8] = '{1, 5, 2, 6, 2, 6, 4, 8};
    int e2 [8] = '{3, 7, 4, 8, 3, 7, 5, 9};
    logic [31:0] x1, x2;
    logic xv, xvn, ce;
    int bad = 0;
    int early = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) butterfly(2'b10, 2'b01, a1[i], a2[i], BF_LAT, x1, x2, xv, xvn, ce);
      else       butterfly(2'b01, 2'b10, a1[i], a2[i], BF_LAT, x1, x2, xv, xvn, ce);
      if (x1 !== 32'(e1[i]) || x2 !== 32'(e2[i])) begin
        bad++;
        $display("FAIL comp_x[%0d]: got %0d,%0d want %0d,%0d", i, x1, x2, e1[i], e2[i]);
      end
      if (i < 7 && ce) early++;
    end
    chk_cnt++; if (bad !== 0) $display("FAIL comp_x_total: got %0d bad want 0", bad); else pass_cnt++;
    chk_cnt++; if (early !== 0) $display("FAIL cal_end_early: got %0d want 0", early); else pass_cnt++;
    chk_cnt++; if (ce !== 1'b1) $display("FAIL cal_end_last: got %b want 1", ce); else pass_cnt++;
    step();
    chk_cnt++; if (o_cal_end !== 1'b0) $display("FAIL cal_end_width: got %b want 0", o_cal_end); else pass_cnt++;
  endtask

  task automatic test_output();
    int exp_d [8] = '{3, 7, 5, 9, 4, 8, 6, 10};
    int bad = 0;
    int early = 0;
    logic last;
    i_ram1_ctrl = 2'b00;
    i_ram2_ctrl = 2'b01;
    for (int k = 0; k < 8; k++) begin
      i_d_out_valid = 1'b1;
      i_d_out_addr  = 16'(k);
      step();
      if (o_data_valid !== 1'b1 || o_data !== 32'(exp_d[k])) begin
        bad++;
        $display("FAIL out_data[%0d]: got %0d (v=%b) want %0d", k, o_data, o_data_valid, exp_d[k]);
      end
      if (k < 7 && o_output_end) early++;
    end
    last = o_output_end;
    i_d_out_valid = 1'b0;
    chk_cnt++; if (bad !== 0) $display("FAIL out_data_total: got %0d bad want 0", bad); else pass_cnt++;
    chk_cnt++; if (early !== 0) $display("FAIL output_end_early: got %0d want 0", early); else pass_cnt++;
    chk_cnt++; if (last !== 1'b1) $display("FAIL output_end_last: got %b want 1", last); else pass_cnt++;
    step();
    chk_cnt++; if ({o_output_end, o_data_valid} !== 2'b00) $display("FAIL output_end_width: got %b want 00", {o_output_end, o_data_valid}); else pass_cnt++;
    chk_cnt++; if (o_err !== 1'b0) $display("FAIL frame_err: got %b want 0", o_err); else pass_cnt++;
  endtask

  task automatic test_error();
    logic [31:0] x1, x2;
    logic xv, xvn, ce;
    butterfly(2'b01, 2'b10, 0, 1, BF_LAT - 1, x1, x2, xv, xvn, ce);
    chk_cnt++; if (o_err !== 1'b1) $display("FAIL err_early_y: got %b want 1", o_err); else pass_cnt++;
    repeat (6) step();
    chk_cnt++; if (o_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", o_err); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] x1, x2;
    logic xv, xvn, ce;
    int pulses = 0;
    int first = -1;
    for (int i = 0; i < 3; i++) butterfly(2'b01, 2'b10, 2 * i, 2 * i + 1, BF_LAT, x1, x2, xv, xvn, ce);
    i_di_valid  = 1'b1;
    i_di_1_addr = 16'd6;
    i_di_2_addr = 16'd7;
    step();
    i_di_valid = 1'b0;
    step();
    i_rst_n = 1'b0;
    #1;
    chk_cnt++; if ({o_x_valid, o_data_valid, o_store_end, o_cal_end, o_output_end, o_err} !== 6'b0) $display("FAIL mid_reset_flags: got %b want 000000", {o_x_valid, o_data_valid, o_store_end, o_cal_end, o_output_end, o_err}); else pass_cnt++;
    chk_cnt++; if ({o_x1, o_x2, o_data} !== 96'b0) $display("FAIL mid_reset_data: got %h %h %h want 0", o_x1, o_x2, o_data); else pass_cnt++;
    step();
    i_rst_n = 1'b1;
    for (int i = 0; i < BF_LAT + 4; i++) begin
      step();
      if (o_cal_end) pulses++;
    end
    chk_cnt++; if (pulses !== 0) $display("FAIL mid_reset_cal_end: got %0d pulses want 0", pulses); else pass_cnt++;
    for (int i = 0; i < 12; i++) begin
      butterfly(2'b01, 2'b10, 0, 1, BF_LAT, x1, x2, xv, xvn, ce);
      if (ce) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    chk_cnt++; if (pulses !== 1 || first !== 11) $display("FAIL post_reset_cal_end: got %0d pulses first %0d want 1 at 11", pulses, first); else pass_cnt++;
    chk_cnt++; if (o_err !== 1'b0) $display("FAIL post_reset_err: got %b want 0", o_err); else pass_cnt++;
  endtask

  task automatic test_n13();
    int early = 0;
    logic last;
    i_n_cfg = 5'd13;
    i_ram1_ctrl = 2'b10;
    i_ram2_ctrl = 2'b00;
    i_store_valid = 1'b1;
    for (int k = 0; k < 8192; k++) begin
      i_store_addr = 16'(k);
      i_store_data = 32'(k);
      step();
      if (k < 8191 && o_store_end) early++;
    end
    last = o_store_end;
    i_store_addr = 16'd0;
    step();
    i_store_valid = 1'b0;
    chk_cnt++; if (early !== 0) $display("FAIL n13_early: got %0d pulses want 0", early); else pass_cnt++;
    chk_cnt++; if (last !== 1'b1) $display("FAIL n13_store_end: got %b want 1", last); else pass_cnt++;
    chk_cnt++; if (o_store_end !== 1'b0) $display("FAIL n13_wrap: got %b want 0", o_store_end); else pass_cnt++;
    chk_cnt++; if (o_err !== 1'b0) $display("FAIL n13_err: got %b want 0", o_err); else pass_cnt++;
  endtask

  initial begin
    i_rst_n       = 1'b0;
    i_n_cfg       = 5'd3;
    i_ram1_ctrl   = 2'b00;
    i_ram2_ctrl   = 2'b00;
    i_store_valid = 1'b0;
    i_store_addr  = '0;
    i_store_data  = '0;
    i_di_valid    = 1'b0;
    i_di_1_addr   = '0;
    i_di_2_addr   = '0;
    i_y_valid     = 1'b0;
    i_y1          = '0;
    i_y2          = '0;
    i_d_out_valid = 1'b0;
    i_d_out_addr  = '0;
    repeat (2) step();
    test_reset();
    i_rst_n = 1'b1;
    step();
    test_store();
    test_stage0();
    test_compute();
    test_output();
    test_error();
    test_reset_mid();
    test_n13();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
